// File: rtl/line_setup.sv
// Bresenham setup: orders and optionally transposes a line's endpoints, then derives deltax, |deltay|, ystep and steep.
// Results appear 4 cycles after start is accepted and are held stable in HOLD until setup_ack; start is ignored while busy.
module line_setup #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] x0_in,
  input  logic [WIDTH-1:0] y0_in,
  input  logic [WIDTH-1:0] x1_in,
  input  logic [WIDTH-1:0] y1_in,
  output logic [WIDTH-1:0] x0,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] deltax,
  output logic [WIDTH-1:0] deltay,
  output logic [WIDTH-1:0] ystep,
  output logic             steep,
  output logic             setup_valid,
  input  logic             setup_ack
);

  localparam logic [WIDTH-1:0] STEP_POS = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] STEP_NEG = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEEP = 3'd1,
    ORDER = 3'd2,
    DELTA = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // working copy of the endpoints, rewritten in place by STEEP and ORDER
  logic [WIDTH-1:0] ax;
  logic [WIDTH-1:0] ay;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] by;
  logic             steep_w;

  logic [WIDTH-1:0] diff_x;
  logic [WIDTH-1:0] diff_y;
  logic [WIDTH-1:0] abs_x;
  logic [WIDTH-1:0] abs_y;
  logic             is_steep;
  logic             a_right_of_b;
  logic             a_below_b;
  logic             acked;

  assign acked = setup_valid && setup_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STEEP;
      STEEP:   state_nxt = ORDER;
      ORDER:   state_nxt = DELTA;
      DELTA:   state_nxt = HOLD;
      HOLD:    if (acked) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Inputs are limited to +/-2048, so differences and their magnitudes never overflow WIDTH bits.
  always_comb begin
    diff_x       = bx - ax;
    diff_y       = by - ay;
    abs_x        = diff_x[WIDTH-1] ? (~diff_x + STEP_POS) : diff_x;
    abs_y        = diff_y[WIDTH-1] ? (~diff_y + STEP_POS) : diff_y;
    is_steep     = abs_y > abs_x;
    a_right_of_b = $signed(ax) > $signed(bx);
    a_below_b    = $signed(ay) < $signed(by);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready       <= 1'b1;
      setup_valid <= 1'b0;
      ax          <= '0;
      ay          <= '0;
      bx          <= '0;
      by          <= '0;
      steep_w     <= 1'b0;
      x0          <= '0;
      y0          <= '0;
      x1          <= '0;
      deltax      <= '0;
      deltay      <= '0;
      ystep       <= STEP_POS;
      steep       <= 1'b0;
    end else begin
      ready       <= (state_nxt == IDLE);
      // valid rises one cycle after HOLD entry so every output is already settled
      setup_valid <= (state == HOLD) && !acked;
      case (state)
        IDLE: begin
          if (start) begin
            ax <= x0_in;
            ay <= y0_in;
            bx <= x1_in;
            by <= y1_in;
          end
        end
        STEEP: begin
          steep_w <= is_steep;
          if (is_steep) begin
            ax <= ay;
            ay <= ax;
            bx <= by;
            by <= bx;
          end
        end
        ORDER: begin
          if (a_right_of_b) begin
            ax <= bx;
            ay <= by;
            bx <= ax;
            by <= ay;
          end
        end
        DELTA: begin
          x0     <= ax;
          y0     <= ay;
          x1     <= bx;
          deltax <= diff_x;
          deltay <= abs_y;
          ystep  <= a_below_b ? STEP_POS : STEP_NEG;
          steep  <= steep_w;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_setup.sv
// Directed bench for line_setup: hand-computed setup results, latency, backpressure and mid-flight reset.
module tb_line_setup;
  localparam int W = 13;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         ready;
  logic [W-1:0] x0_in, y0_in, x1_in, y1_in;
  logic [W-1:0] x0, y0, x1, deltax, deltay, ystep;
  logic         steep;
  logic         setup_valid;
  logic         setup_ack;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  line_setup #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .x0_in(x0_in), .y0_in(y0_in), .x1_in(x1_in), .y1_in(y1_in),
    .x0(x0), .y0(y0), .x1(x1), .deltax(deltax), .deltay(deltay),
    .ystep(ystep), .steep(steep), .setup_valid(setup_valid), .setup_ack(setup_ack)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic es, input logic [W-1:0] ex0,
                            input logic [W-1:0] ey0, input logic [W-1:0] ex1,
                            input logic [W-1:0] edx, input logic [W-1:0] edy,
                            input logic [W-1:0] eys);
    check({tag, ".steep"},  W'(steep), W'(es));
    check({tag, ".x0"},     x0,     ex0);
    check({tag, ".y0"},     y0,     ey0);
    check({tag, ".x1"},     x1,     ex1);
    check({tag, ".deltax"}, deltax, edx);
    check({tag, ".deltay"}, deltay, edy);
    check({tag, ".ystep"},  ystep,  eys);
  endtask

  // Called just after a rising edge; returns just after the edge where valid must first be seen.
  task automatic launch(input string tag, input logic [W-1:0] ax, input logic [W-1:0] ay,
                        input logic [W-1:0] bx, input logic [W-1:0] by);
    x0_in = ax; y0_in = ay; x1_in = bx; y1_in = by;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".ready_busy"}, W'(ready), W'(1'b0));
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".valid_early"}, W'(setup_valid), W'(1'b0));
    @(posedge clk); #1;
    check({tag, ".valid_n4"}, W'(setup_valid), W'(1'b1));
    check({tag, ".ready_hold"}, W'(ready), W'(1'b0));
  endtask

  task automatic acknowledge(input string tag);
    setup_ack = 1'b1;
    @(posedge clk); #1;
    setup_ack = 1'b0;
    check({tag, ".valid_after_ack"}, W'(setup_valid), W'(1'b0));
    check({tag, ".ready_after_ack"}, W'(ready), W'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; setup_ack = 1'b0;
    x0_in = '0; y0_in = '0; x1_in = '0; y1_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", W'(ready), W'(1'b1));
    check("rst.valid", W'(setup_valid), W'(1'b0));
    check_outs("rst", 1'b0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'h0001);
    rst = 1'b0;
    @(posedge clk); #1;

    // (0,0)->(10,4)
    launch("basic", 13'd0, 13'd0, 13'd10, 13'd4);
    check_outs("basic", 1'b0, 13'd0, 13'd0, 13'd10, 13'd10, 13'd4, 13'h0001);
    acknowledge("basic");

    // (3,1)->(5,9): transposed
    launch("steep", 13'd3, 13'd1, 13'd5, 13'd9);
    check_outs("steep", 1'b1, 13'd1, 13'd3, 13'd9, 13'd8, 13'd2, 13'h0001);
    acknowledge("steep");

    // (10,2)->(2,8): reordered, descending
    launch("rev", 13'd10, 13'd2, 13'd2, 13'd8);
    check_outs("rev", 1'b0, 13'd2, 13'd8, 13'd10, 13'd8, 13'd6, 13'h1FFF);
    acknowledge("rev");

    // (0,0)->(5,5): tie is not steep
    launch("tie", 13'd0, 13'd0, 13'd5, 13'd5);
    check_outs("tie", 1'b0, 13'd0, 13'd0, 13'd5, 13'd5, 13'd5, 13'h0001);
    acknowledge("tie");

    // (7,7)->(7,7): degenerate point
    launch("point", 13'd7, 13'd7, 13'd7, 13'd7);
    check_outs("point", 1'b0, 13'd7, 13'd7, 13'd7, 13'd0, 13'd0, 13'h1FFF);
    acknowledge("point");

    // (-5,3)->(-1,-2): negative coordinates, steep and reordered
    launch("neg", 13'h1FFB, 13'd3, 13'h1FFF, 13'h1FFE);
    check_outs("neg", 1'b1, 13'h1FFE, 13'h1FFF, 13'd3, 13'd5, 13'd4, 13'h1FFF);
    acknowledge("neg");

    // Backpressure: hold ack low while pulsing start with other endpoints
    launch("bp", 13'd3, 13'd1, 13'd5, 13'd9);
    for (int i = 0; i < 10; i++) begin
      start = (i % 2 == 0);
      x0_in = 13'd100; y0_in = 13'd50; x1_in = 13'h1FFD; y1_in = 13'd7;
      @(posedge clk); #1;
      check("bp.valid_held", W'(setup_valid), W'(1'b1));
      check("bp.ready_low", W'(ready), W'(1'b0));
      check_outs("bp.hold", 1'b1, 13'd1, 13'd3, 13'd9, 13'd8, 13'd2, 13'h0001);
    end
    start = 1'b0;
    acknowledge("bp");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("bp.no_queue_valid", W'(setup_valid), W'(1'b0));
      check("bp.idle_ready", W'(ready), W'(1'b1));
    end
    check_outs("bp.kept", 1'b1, 13'd1, 13'd3, 13'd9, 13'd8, 13'd2, 13'h0001);

    // Reset while in ORDER: start at edge N, ORDER after N+1, reset sampled at N+2
    x0_in = 13'd10; y0_in = 13'd2; x1_in = 13'd2; y1_in = 13'd8;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid.ready", W'(ready), W'(1'b1));
    check("mid.valid", W'(setup_valid), W'(1'b0));
    check_outs("mid", 1'b0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'h0001);
    repeat (4) @(posedge clk);
    #1;
    check("mid.discarded", W'(setup_valid), W'(1'b0));

    launch("after", 13'd0, 13'd0, 13'd10, 13'd4);
    check_outs("after", 1'b0, 13'd0, 13'd0, 13'd10, 13'd10, 13'd4, 13'h0001);
    acknowledge("after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_setup.md
# line_setup

Front-end stage of the line-drawing core. It accepts a line's two endpoints and produces the Bresenham setup operands for the x-counter and error datapath: swapped and ordered endpoints, deltax, |deltay|, ystep and the steep flag. The block is a small multi-cycle FSM with a ready/valid-style handshake on both sides. It holds its results stable until the downstream control acknowledges them.

## Interface
- WIDTH, 13, bit width of all coordinates and setup operands (signed two's complement)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; endpoints are captured when start & ready
- ready  output  1  high only in IDLE
- x0_in, y0_in, x1_in, y1_in  input  WIDTH each  raw endpoints (signed)
- x0, y0, x1  output  WIDTH each  setup endpoints after steep swap and ordering
- deltax  output  WIDTH  x1 - x0, always >= 0
- deltay  output  WIDTH  |y1 - y0|
- ystep  output  WIDTH  +1 (13'h0001) or -1 (13'h1FFF)
- steep  output  1  1 when the line was transposed; downstream un-swaps plotted (x,y)
- setup_valid  output  1  outputs are valid and stable
- setup_ack  input  1  consumer accepted the outputs; sampled only while setup_valid

## Operation
- States: IDLE, STEEP, ORDER, DELTA, HOLD. All outputs are registered.
- **IDLE:**
  - ready=1.
  - On start, capture the four inputs into working registers ax, ay, bx, by, then go to STEEP.
  - When start is not asserted, stay in IDLE.
- **STEEP:**
  - Compute steep = |by-ay| > |bx-ax| (strict).
  - A tie (|dy|==|dx|) gives steep=0.
  - If steep, swap ax<->ay and bx<->by.
  - Go to ORDER.
- **ORDER:**
  - If ax > bx (signed compare), swap the endpoints: ax<->bx and ay<->by.
  - Go to DELTA.
- **DELTA:**
  - deltax = bx-ax.
  - deltay = |by-ay|.
  - ystep = +1 if ay < by, else -1.
  - ystep is -1 when ay==by; that value is don't-care downstream because deltay=0.
  - Load x0=ax, y0=ay, x1=bx.
  - Go to HOLD.
- **HOLD:**
  - setup_valid=1.
  - All outputs hold.
  - On setup_ack, go to IDLE.
- **Input range:** inputs are restricted to [-2048, 2047]. Every difference then fits in WIDTH bits.
  - Out-of-range inputs are not detected.
  - Arithmetic wraps modulo 2^WIDTH.
- **Start outside IDLE:** start is ignored. There is no queuing.
- **Degenerate point (x0_in==x1_in, y0_in==y1_in):** result is steep=0, deltax=0, deltay=0, ystep=-1.

## Timing
- **Reset:**
  - state=IDLE.
  - ready=1, setup_valid=0, steep=0.
  - x0, y0, x1, deltax, deltay = 0.
  - ystep=13'h0001.
  - Working registers = 0.
- **Latency:** start & ready sampled at edge N gives setup_valid high after edge N+4. That is 4 cycles: STEEP, ORDER, DELTA, then the HOLD entry.
- **ready:** deasserts after edge N and reasserts the cycle after the acknowledging edge.
- **Ack:**
  - setup_ack in HOLD at edge M clears setup_valid after M.
  - A new start is accepted at the earliest at edge M+1.
  - setup_ack outside HOLD has no effect.
- **Backpressure:** HOLD may last indefinitely. Outputs must not change while setup_valid=1.
- **Outputs after ack:** x0, y0, x1, deltax, deltay, ystep and steep keep their last values until the next DELTA state.
- **Reset mid-operation:** rst in any state returns to reset values at the next edge. A partially computed setup is discarded. rst has priority over start and setup_ack.

## Test plan
- **Basic line:** (0,0)->(10,4), start one cycle, ack when valid.
  - Required: valid exactly 4 cycles after the start edge.
  - Outputs: steep=0, x0=0, y0=0, x1=10, deltax=10, deltay=4, ystep=13'h0001.
- **Steep line:** (3,1)->(5,9).
  - Required: steep=1, x0=1, y0=3, x1=9, deltax=8, deltay=2, ystep=+1.
- **Reversed, descending line:** (10,2)->(2,8).
  - Required: steep=0, x0=2, y0=8, x1=10, deltax=8, deltay=6, ystep=13'h1FFF.
- **Tie, then degenerate point:** (0,0)->(5,5), then (7,7)->(7,7).
  - Tie required: steep=0, deltax=5, deltay=5, ystep=+1.
  - Point required: steep=0, x0=x1=7, y0=7, deltax=0, deltay=0, ystep=13'h1FFF.
- **Backpressure:** hold setup_ack=0 for 10 cycles after valid while pulsing start with different endpoints.
  - Outputs and setup_valid stay constant and ready=0 throughout.
  - Ack: valid drops the next cycle and ready=1.
  - The pulsed starts are never processed.
- **Reset mid-operation:** assert rst for one cycle while in ORDER.
  - Next cycle: ready=1, setup_valid=0, all outputs at reset values.
  - A subsequent start with (0,0)->(10,4) yields the basic-line result.
